// File: rtl/serial_add_pkg.sv
// Shared encodings and defaults for the bit-serial adder controller.
package serial_add_pkg;
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/serial_add_ctrl_fa.sv
// Single-bit full-adder cell; the only arithmetic in the serial datapath.
module serial_add_ctrl_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell walked LSB-first over WIDTH bits.
// Define SERIAL_ADD_SUB_EN to add the 'sub' port (a - b via inverted B and forced carry-in).
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             s_bit;
   logic             c_bit;
   logic [WIDTH-1:0] b_cap;
   logic             c_cap;

   // Subtraction is two's complement: a + ~b + 1.
   always_comb begin
      b_cap = b;
      c_cap = cin;
`ifdef SERIAL_ADD_SUB_EN
      if (sub) begin
         b_cap = ~b;
         c_cap = 1'b1;
      end
`endif
   end

   serial_add_ctrl_fa u_fa (
      .a  (sh_a[0]),
      .b  (sh_b[0]),
      .ci (carry),
      .s  (s_bit),
      .co (c_bit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         cnt   <= '0;
         carry <= 1'b0;
         sh_a  <= '0;
         sh_b  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sh_a  <= a;
                  sh_b  <= b_cap;
                  carry <= c_cap;
                  sum   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               // Result fills from the MSB side so bit 0 lands in place after WIDTH shifts.
               sum   <= {s_bit, sum[WIDTH-1:1]};
               sh_a  <= sh_a >> 1;
               sh_b  <= sh_b >> 1;
               carry <= c_bit;
               if (cnt == CW'(WIDTH - 1)) begin
                  cnt   <= '0;
                  cout  <= c_bit;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8); subtract steps build only with SERIAL_ADD_SUB_EN.
module tb_serial_add_ctrl;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;

   int checks   = 0;
   int failures = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
`ifdef SERIAL_ADD_SUB_EN
      .sub   (sub),
`endif
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called right after the accepting edge: walks the remaining busy cycles, the done cycle, and one more.
   task automatic finish_run(input string tag, input logic [W-1:0] es, input logic ec);
      chk({tag, "_busy0"}, {31'd0, busy}, 32'd1);
      for (int i = 1; i < W; i++) begin
         tick();
         chk({tag, "_busy"}, {30'd0, busy, done}, 32'd2);
      end
      tick();
      chk({tag, "_done"}, {30'd0, busy, done}, 32'd1);
      chk({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
      chk({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
      tick();
      chk({tag, "_after"}, {22'd0, busy, done, sum}, {24'd0, es});
   endtask

   task automatic run_add(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic ci, input logic sb, input logic [W-1:0] es, input logic ec);
      a = av; b = bv; cin = ci; sub = sb; start = 1'b1;
      tick();
      start = 1'b0; a = 8'hC3; b = 8'h3C; cin = ~ci;
      finish_run(tag, es, ec);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
      tick();
      chk("reset", {21'd0, busy, done, sum, cout}, 32'd0);
      @(negedge clk); rst = 1'b0;
      tick();
      chk("idle", {21'd0, busy, done, sum, cout}, 32'd0);

      run_add("t1_5a_33", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0);
      run_add("t2_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
      run_add("t2_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1);

      // Reset on the 4th RUN cycle must clear outputs without waiting for a clock edge.
      a = 8'h5A; b = 8'h33; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick(); tick();
      chk("t4_pre_busy", {31'd0, busy}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("t4_async", {21'd0, busy, done, sum, cout}, 32'd0);
      @(negedge clk); rst = 1'b0;
      tick(); tick();
      chk("t4_no_done", {30'd0, busy, done}, 32'd0);
      run_add("t4_01_01", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0);

      // Start re-pulsed on the 3rd busy cycle is ignored.
      a = 8'h5A; b = 8'h33; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      chk("t3_busy1", {31'd0, busy}, 32'd1);
      tick(); tick();
      a = 8'h11; b = 8'h22; cin = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 4; i < W; i++) tick();
      chk("t3_last_busy", {30'd0, busy, done}, 32'd2);
      tick();
      chk("t3_done", {30'd0, busy, done}, 32'd1);
      chk("t3_sum", {24'd0, sum}, 32'h8D);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t3_no_second", {22'd0, busy, done, sum}, 32'h8D);
      end

      // Start during DONE is dropped; the same start seen in the following IDLE cycle is taken.
      a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 1; i < W; i++) tick();
      tick();
      chk("t5_done", {30'd0, busy, done}, 32'd1);
      chk("t5_sum", {24'd0, sum, cout}, 32'h1FE);
      a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
      tick();
      chk("t5_ignored", {22'd0, busy, done, sum}, 32'hFF);
      tick();
      start = 1'b0;
      chk("t5_accept_sum", {24'd0, sum}, 32'h00);
      finish_run("t5_b2b", 8'h02, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
      run_add("t6_10_m_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
      run_add("t6_00_m_01", 8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
